// File: rtl/ratio_detector_pkg.sv
// ratio_detector_pkg
//   Shared types and default constants for the ratio detector.
//   - state_e         : measurement FSM states
//   - DEF_CNT_W       : default period counter width
//   - DEF_MAX_PERIOD  : default timeout threshold in Clock cycles
//   - DEF_LOCK_COUNT  : default number of consecutive equal periods needed to lock
//   - DEF_DIV0/1      : default expected periods for divider select 0 / 1
`timescale 1ns/1ps
package ratio_detector_pkg;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_MAX_PERIOD = 255;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_DIV0       = 2;
  localparam int DEF_DIV1       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/rd_edge_detect.sv
// rd_edge_detect
//   Samples ClockIn in the Clock domain and flags its rising edges.
//   Ports:
//     Clock   : in  - sampling clock, rising edge
//     nReset  : in  - asynchronous active-low reset
//     ClockIn : in  - divided clock treated as data
//     Rise    : out - high for one cycle per detected 0->1 transition
//   Macro RATIO_DETECTOR_SYNC_EN: when defined, a two-flop synchroniser sits
//   in front of the sample register (two extra cycles of edge latency).
`timescale 1ns/1ps
module rd_edge_detect (
  input  logic Clock,
  input  logic nReset,
  input  logic ClockIn,
  output logic Rise
);

  logic src;
  logic in_q;
  logic prev_q;

`ifdef RATIO_DETECTOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], ClockIn};
    end
  end

  assign src = sync_q[1];
`else
  assign src = ClockIn;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      in_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      in_q   <= src;
      prev_q <= in_q;
    end
  end

  assign Rise = in_q & ~prev_q;

endmodule

// File: rtl/ratio_detector.sv
// ratio_detector
//   Measures the rising-to-rising period of ClockIn in Clock cycles, locks
//   once LOCK_COUNT consecutive equal periods are seen, and recovers which
//   divider (DIV0 / DIV1) produced it.
//   Ports:
//     Clock      : in  - single clock, rising edge
//     nReset     : in  - asynchronous active-low reset
//     ClockIn    : in  - divided clock under measurement
//     Period     : out - last measured period (CNT_W bits)
//     Locked     : out - period stable
//     RatioValid : out - Locked and Period is DIV0 or DIV1
//     SelDetect  : out - 1 when Period matches DIV1 (meaningful with RatioValid)
//     Error      : out - one-cycle pulse on timeout or loss of lock
//   Macro RATIO_DETECTOR_SYNC_EN: adds a two-flop synchroniser on ClockIn.
`timescale 1ns/1ps
module ratio_detector
  import ratio_detector_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int DIV0       = DEF_DIV0,
  parameter int DIV1       = DEF_DIV1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             ClockIn,
  output logic [CNT_W-1:0] Period,
  output logic             Locked,
  output logic             RatioValid,
  output logic             SelDetect,
  output logic             Error
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]   MAX_C    = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]   DIV0_C   = CNT_W'(DIV0);
  localparam logic [CNT_W-1:0]   DIV1_C   = CNT_W'(DIV1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_C   = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic               SAME_DIV = (DIV0 == DIV1);

  logic rise;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               locked_q, locked_d;
  logic               ratio_valid_q, ratio_valid_d;
  logic               sel_q, sel_d;
  logic               error_q, error_d;
  logic               timeout;

  rd_edge_detect u_edge (
    .Clock   (Clock),
    .nReset  (nReset),
    .ClockIn (ClockIn),
    .Rise    (rise)
  );

  // An edge coinciding with the counter at MAX_PERIOD wins over the timeout.
  assign timeout = (cnt_q == MAX_C) && !rise;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
    period_d = period_q;
    locked_d = locked_q;
    error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
          match_d = '0;
        end
      end

      ST_MEASURE: begin
        if (rise) begin
          cnt_d    = CNT_ONE;
          period_d = cnt_q;
          match_d  = (cnt_q == period_q) ? match_q + MATCH_ONE : MATCH_ONE;
          if (match_d >= LOCK_C) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LOCKED: begin
        if (rise) begin
          cnt_d = CNT_ONE;
          if (cnt_q != period_q) begin
            state_d  = ST_MEASURE;
            period_d = cnt_q;
            match_d  = MATCH_ONE;
            locked_d = 1'b0;
            error_d  = 1'b1;
          end
        end else if (timeout) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          locked_d = 1'b0;
          error_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    endcase

    // Derived from next-state values so they move in lockstep with Locked.
    ratio_valid_d = locked_d && ((period_d == DIV0_C) || (period_d == DIV1_C));
    sel_d         = ratio_valid_d && !SAME_DIV && (period_d == DIV1_C);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      match_q       <= '0;
      period_q      <= '0;
      locked_q      <= 1'b0;
      ratio_valid_q <= 1'b0;
      sel_q         <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      match_q       <= match_d;
      period_q      <= period_d;
      locked_q      <= locked_d;
      ratio_valid_q <= ratio_valid_d;
      sel_q         <= sel_d;
      error_q       <= error_d;
    end
  end

  assign Period     = period_q;
  assign Locked     = locked_q;
  assign RatioValid = ratio_valid_q;
  assign SelDetect  = sel_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_ratio_detector.sv
// tb_ratio_detector
//   Scoreboard bench: stimulus pushes the expected Locked-rise / Error events
//   (with the cycle they must appear in) and a monitor compares every event
//   the DUT produces against the queue.
`timescale 1ns/1ps
module tb_ratio_detector;

  localparam int CNT_W = 8;
  localparam int MAX_P = 255;
`ifdef RATIO_DETECTOR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int K_NONE = 0;
  localparam int K_LOCK = 1;
  localparam int K_ERR  = 2;

  logic             Clock   = 1'b0;
  logic             nReset  = 1'b0;
  logic             ClockIn = 1'b0;
  logic [CNT_W-1:0] Period;
  logic             Locked;
  logic             RatioValid;
  logic             SelDetect;
  logic             Error;

  typedef struct {
    int               kind;
    int               cyc;
    logic [CNT_W-1:0] period;
    logic             rv;
    logic             sel;
    logic             locked;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  int  last_d = 0;
  bit  prev_l = 1'b0;

  ratio_detector #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAX_P),
    .LOCK_COUNT (4),
    .DIV0       (2),
    .DIV1       (4)
  ) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .ClockIn    (ClockIn),
    .Period     (Period),
    .Locked     (Locked),
    .RatioValid (RatioValid),
    .SelDetect  (SelDetect),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic push(input int kind, input int c, input int per, input bit rv, input bit sel, input bit lk);
    ev_t e;
    e.kind   = kind;
    e.cyc    = c;
    e.period = CNT_W'(per);
    e.rv     = rv;
    e.sel    = sel;
    e.locked = lk;
    exp_q.push_back(e);
  endtask

  // One ClockIn period of p cycles: high p/2 cycles, then low. The rising
  // edge is driven at the first negedge; an expected event can be attached.
  task automatic pulse(input int p, input int kind, input int eper, input bit erv, input bit esel);
    int d;
    @(negedge Clock);
    ClockIn = 1'b1;
    d = cyc;
    if (kind != K_NONE) push(kind, d + LAT, eper, erv, esel, kind == K_LOCK);
    for (int i = 1; i < p / 2; i++) @(negedge Clock);
    @(negedge Clock);
    ClockIn = 1'b0;
    for (int i = 1; i < p - p / 2; i++) @(negedge Clock);
    last_d = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: every Error pulse and every Locked rise is an event.
  initial begin : monitor
    int  kind;
    ev_t e;
    forever begin
      @(negedge Clock);
      kind = K_NONE;
      if (Error === 1'b1) kind = K_ERR;
      else if (Locked === 1'b1 && !prev_l) kind = K_LOCK;
      prev_l = (Locked === 1'b1);
      if (kind != K_NONE) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind=%0d cyc=%0d Period=%0d Locked=%b, required no event",
                   kind, cyc, Period, Locked);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind || e.cyc != cyc || Period !== e.period || RatioValid !== e.rv ||
              SelDetect !== e.sel || Locked !== e.locked) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d P=%0d L=%b RV=%b S=%b, required kind=%0d cyc=%0d P=%0d L=%b RV=%b S=%b",
                     kind, cyc, Period, Locked, RatioValid, SelDetect,
                     e.kind, e.cyc, e.period, e.locked, e.rv, e.sel);
          end else begin
            $display("event kind=%0d cyc=%0d Period=%0d Locked=%b RatioValid=%b SelDetect=%b ok",
                     kind, cyc, Period, Locked, RatioValid, SelDetect);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    repeat (3) @(negedge Clock);
    chk("reset_period", 32'(Period), 32'd0);
    chk("reset_locked", 32'(Locked), 32'd0);
    chk("reset_ratiovalid", 32'(RatioValid), 32'd0);
    chk("reset_seldetect", 32'(SelDetect), 32'd0);
    chk("reset_error", 32'(Error), 32'd0);
    nReset = 1'b1;

    // Clock/2 from reset: lock one cycle after the 5th edge, period 2, sel 0
    for (int i = 1; i <= 10; i++) pulse(2, (i == 5) ? K_LOCK : K_NONE, 2, 1'b1, 1'b0);

    // ClockIn stuck low while locked: timeout, Period holds 2
    push(K_ERR, last_d + LAT + MAX_P, 2, 1'b0, 1'b0, 1'b0);
    idle(300);

    // Relock at 2, then switch divider to period 4
    for (int i = 1; i <= 8; i++) pulse(2, (i == 5) ? K_LOCK : K_NONE, 2, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++)
      pulse(4, (i == 2) ? K_ERR : ((i == 5) ? K_LOCK : K_NONE), 4, i == 5, i == 5);

    // Short asynchronous reset pulse while locked
    @(negedge Clock);
    #1 nReset = 1'b0;
    #1;
    chk("async_period", 32'(Period), 32'd0);
    chk("async_locked", 32'(Locked), 32'd0);
    chk("async_ratiovalid", 32'(RatioValid), 32'd0);
    chk("async_seldetect", 32'(SelDetect), 32'd0);
    chk("async_error", 32'(Error), 32'd0);
    #1.5 nReset = 1'b1;
    for (int i = 1; i <= 6; i++) pulse(2, (i == 5) ? K_LOCK : K_NONE, 2, 1'b1, 1'b0);

    // Alternating 3,5 periods from a clean start: never locks, no Error
    @(negedge Clock);
    #1 nReset = 1'b0;
    #5 nReset = 1'b1;
    for (int i = 0; i < 8; i++) pulse((i % 2 == 0) ? 3 : 5, K_NONE, 0, 1'b0, 1'b0);
    chk("alternating_locked", 32'(Locked), 32'd0);

    // Timeout from MEASURE; last measured period was 3
    push(K_ERR, last_d + LAT + MAX_P, 3, 1'b0, 1'b0, 1'b0);
    idle(300);

    // Edge exactly when the counter reaches MAX_PERIOD is an edge, then
    // stable period 6: locks but is not a valid ratio
    pulse(MAX_P, K_NONE, 0, 1'b0, 1'b0);
    pulse(MAX_P, K_NONE, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) pulse(6, (i == 5) ? K_LOCK : K_NONE, 6, 1'b0, 1'b0);
    idle(4);
    chk("period6_period", 32'(Period), 32'd6);
    chk("period6_locked", 32'(Locked), 32'd1);
    chk("period6_ratiovalid", 32'(RatioValid), 32'd0);
    chk("pending_events", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
